// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module   : cp0
// Purpose  : Coprocessor-0 exception/interrupt responder with SR, Cause, EPC,
//            Count and PRId registers, mfc0/mtc0/eret service from M stage.
// Revision : 1.0 - initial release
// ============================================================================
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_2021
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic [6:2]  ExcCode_in,
    input  logic [7:2]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    localparam logic [4:0] c_ADDR_COUNT = 5'd9;
    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;
    localparam logic [4:0] c_ADDR_PRID  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_count;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_int_req;
    logic        w_sr_wr;
    logic        w_epc_wr;
    logic        w_cnt_wr;
    logic        w_unused;

    assign w_int_pend = r_ie & ~r_exl & (|(HWInt & r_im));
    assign w_exc_pend = ~r_exl & (ExcCode_in != 5'd0);
    assign w_int_req  = ~reset & (w_int_pend | w_exc_pend);
    assign IntReq     = w_int_req;

    // The mtc0 sitting in M is the victim of a taken request, so its write dies.
    assign w_sr_wr  = WE & ~w_int_req & (A == c_ADDR_SR);
    assign w_epc_wr = WE & ~w_int_req & (A == c_ADDR_EPC);
    assign w_cnt_wr = WE & ~w_int_req & (A == c_ADDR_COUNT);

    assign w_unused = &{1'b0, DIn[31:16], DIn[9:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
            r_count   <= 32'd0;
        end else begin
            r_ip <= HWInt;

            if (w_int_req) begin
                r_exl     <= 1'b1;
                r_exccode <= w_int_pend ? 5'd0 : ExcCode_in;
                r_epc     <= VPC;
            end else begin
                if (w_sr_wr) begin
                    r_im <= DIn[15:10];
                    r_ie <= DIn[0];
                end
                // eret overrides an SR write on the EXL bit only.
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end else if (w_sr_wr) begin
                    r_exl <= DIn[1];
                end
                if (w_epc_wr) begin
                    r_epc <= DIn;
                end
            end

            if (w_cnt_wr) begin
                r_count <= DIn;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign EPC_out = r_epc;

    always_comb begin
        DOut = 32'd0;
        case (A)
            c_ADDR_COUNT: DOut = r_count;
            c_ADDR_SR:    DOut = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_ADDR_CAUSE: DOut = {16'd0, r_ip, 3'd0, r_exccode, 2'd0};
            c_ADDR_EPC:   DOut = r_epc;
            c_ADDR_PRID:  DOut = PRID;
            default:      DOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0
// Purpose  : Scenario-driven scoreboard bench for cp0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic [6:2]  ExcCode_in;
    logic [7:2]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_vec;
    int          n_err;

    cp0 #(.PRID(32'h0000_2021)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .DIn        (DIn),
        .WE         (WE),
        .VPC        (VPC),
        .ExcCode_in (ExcCode_in),
        .HWInt      (HWInt),
        .EXLClr     (EXLClr),
        .IntReq     (IntReq),
        .EPC_out    (EPC_out),
        .DOut       (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr);
        A = addr;
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; DIn = 32'd0; VPC = 32'd0; ExcCode_in = 5'd0;
        HWInt = 6'd0; EXLClr = 1'b0; A = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        ExcCode_in = 5'd10;
        HWInt = 6'h3f;
        tick();
        tick();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h0000_2021);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL reset_intreq: got %h want %h", IntReq, e); end
        foreach (exp_q[i]) begin end
        rd(5'd9);  e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL reset_count: got %h want %h", DOut, e); end
        rd(5'd12); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL reset_sr: got %h want %h", DOut, e); end
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL reset_cause: got %h want %h", DOut, e); end
        rd(5'd14); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL reset_epc: got %h want %h", DOut, e); end
        rd(5'd15); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL reset_prid: got %h want %h", DOut, e); end
        e = exp_q.pop_front(); n_vec++;
        if (EPC_out !== e) begin n_err++; $display("FAIL reset_epc_out: got %h want %h", EPC_out, e); end
        reset = 1'b0;
        idle();
        #1;
    endtask

    task automatic test_masked_interrupt();
        do_reset();
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0; DIn = 32'd0;
        HWInt = 6'b000001; VPC = 32'h3010;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL int_req: got %h want %h", IntReq, e); end
        tick();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h0000_0403);
        exp_q.push_back(32'h0000_0400);
        exp_q.push_back(32'h3010);
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL int_req_after: got %h want %h", IntReq, e); end
        rd(5'd12); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL int_sr: got %h want %h", DOut, e); end
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL int_cause: got %h want %h", DOut, e); end
        e = exp_q.pop_front(); n_vec++;
        if (EPC_out !== e) begin n_err++; $display("FAIL int_epc: got %h want %h", EPC_out, e); end
    endtask

    task automatic test_exception();
        do_reset();
        ExcCode_in = 5'd10; VPC = 32'h3020;
        WE = 1'b1; A = 5'd14; DIn = 32'h5555;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL exc_req: got %h want %h", IntReq, e); end
        tick();
        idle();
        exp_q.push_back(32'h28);
        exp_q.push_back(32'h3020);
        exp_q.push_back(32'h2);
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL exc_cause: got %h want %h", DOut, e); end
        rd(5'd14); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL exc_epc: got %h want %h", DOut, e); end
        rd(5'd12); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL exc_sr: got %h want %h", DOut, e); end
    endtask

    task automatic test_priority_eret();
        do_reset();
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0; DIn = 32'd0;
        HWInt = 6'b000001; ExcCode_in = 5'd12; VPC = 32'h3040;
        tick();
        HWInt = 6'd0; ExcCode_in = 5'd0; VPC = 32'd0;
        exp_q.push_back(32'h0000_0400);
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL prio_cause: got %h want %h", DOut, e); end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        exp_q.push_back(32'h0000_0401);
        exp_q.push_back(32'h3040);
        rd(5'd12); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL eret_sr: got %h want %h", DOut, e); end
        e = exp_q.pop_front(); n_vec++;
        if (EPC_out !== e) begin n_err++; $display("FAIL eret_epc: got %h want %h", EPC_out, e); end
    endtask

    task automatic test_exl_block();
        do_reset();
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0; DIn = 32'd0;
        ExcCode_in = 5'd8; VPC = 32'h3050;
        tick();
        ExcCode_in = 5'd4; HWInt = 6'b000001; VPC = 32'h3060;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL exl_block_req: got %h want %h", IntReq, e); end
        tick();
        idle();
        exp_q.push_back(32'h3050);
        exp_q.push_back(32'h0000_0420);
        e = exp_q.pop_front(); n_vec++;
        if (EPC_out !== e) begin n_err++; $display("FAIL exl_block_epc: got %h want %h", EPC_out, e); end
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL exl_block_cause: got %h want %h", DOut, e); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        WE = 1'b1; A = 5'd9; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0; DIn = 32'd0;
        exp_q.push_back(32'hFFFF_FFFF);
        rd(5'd9); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL count_write: got %h want %h", DOut, e); end
        tick();
        exp_q.push_back(32'd0);
        rd(5'd9); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL count_wrap: got %h want %h", DOut, e); end
        WE = 1'b1; A = 5'd15; DIn = 32'hDEAD_BEEF;
        tick();
        A = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0; DIn = 32'd0;
        exp_q.push_back(32'h0000_2021);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd2);
        rd(5'd15); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL prid_ro: got %h want %h", DOut, e); end
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL cause_ro: got %h want %h", DOut, e); end
        rd(5'd9); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL count_inc: got %h want %h", DOut, e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ExcCode_in = 5'd8; VPC = 32'h3070;
        tick();
        ExcCode_in = 5'd0; VPC = 32'd0;
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1;
        tick();
        WE = 1'b0; DIn = 32'd0; EXLClr = 1'b0;
        exp_q.push_back(32'h0000_FC01);
        exp_q.push_back(32'd0);
        rd(5'd12); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL sr_eret_merge: got %h want %h", DOut, e); end
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL idle_req: got %h want %h", IntReq, e); end
        HWInt = 6'b100000; VPC = 32'h3080;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if ({31'd0, IntReq} !== e) begin n_err++; $display("FAIL hw7_req: got %h want %h", IntReq, e); end
        tick();
        idle();
        exp_q.push_back(32'h0000_8000);
        exp_q.push_back(32'h3080);
        rd(5'd13); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL hw7_cause: got %h want %h", DOut, e); end
        rd(5'd14); e = exp_q.pop_front(); n_vec++;
        if (DOut !== e) begin n_err++; $display("FAIL hw7_epc: got %h want %h", DOut, e); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        idle();
        test_reset();
        test_masked_interrupt();
        test_exception();
        test_priority_eret();
        test_exl_block();
        test_count_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
